admo_alu_arbiter: RTL and testbench
===================================

# admo_alu_arbiter

Shares one combinational `admo_alu` instance between two requesters, for example the execute stage and an address-generation or auxiliary unit. Each requester issues operand/operator transactions over a valid/ready handshake. The arbiter grants the ALU round-robin, registers the ALU result and returns it on a per-requester response handshake. Throughput is one operation per cycle under continuous acceptance; latency is one cycle from accept to response.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32, from admo_defs.v): operand/result width.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `reqN_valid_i`  in  1  requester N (N=0,1) holds a valid operation.
- `reqN_ready_o`  out  1  operation from requester N is accepted this cycle.
- `reqN_operand_a_i`, `reqN_operand_b_i`  in  DATA_WIDTH  operands.
- `reqN_operator_i`  in  4  ALU operator code (`` `ALU_* `` from admo_defs.v).
- `rspN_valid_o`  out  1  a result for requester N is held.
- `rspN_ready_i`  in  1  requester N consumes the result.
- `rspN_result_o`  out  DATA_WIDTH  result; valid only while `rspN_valid_o` is high.
- `alu_operand_a_o`, `alu_operand_b_o`  out  DATA_WIDTH  to the shared ALU.
- `alu_operator_o`  out  4  to the shared ALU.
- `alu_result_i`  in  DATA_WIDTH  from the shared ALU (combinational).

## Operation
- FSM states:
  - IDLE: no result held.
  - RESP: result register full; `owner` identifies the requester that issued it.
- Issue slot is open when the state is IDLE, or when the state is RESP and `rsp<owner>_valid_o & rsp<owner>_ready_i` (the response completes this cycle).
- Grant, when the slot is open:
  - Only one `reqN_valid_i` high: that requester is granted.
  - Both high: the requester that is not `last_grant` is granted.
  - No slot open: no grant.
- `reqN_ready_o` = slot open & grant==N. It is combinational from `reqN_valid_i`, `rsp*_ready_i` and state.
- ALU mux:
  - With a grant: the granted requester's operands and operator drive `alu_*_o`.
  - Without a grant: all-zero operands and operator 4'h0.
- On accept, at the clock edge:
  - result_reg <= `alu_result_i`
  - owner <= granted requester
  - last_grant <= granted requester
  - state <= RESP
- On response completion with no new accept: state <= IDLE.
- On response completion with a new accept in the same cycle: stay in RESP with the new owner and result.
- `rspN_valid_o` = (state==RESP) & owner==N. `rspN_result_o` = result_reg for both N. Consumers qualify the result with their own valid.
- Arithmetic wraps modulo 2^DATA_WIDTH, as produced by the ALU. The arbiter does not modify the result.
- Protocol rule: once `reqN_valid_i` is raised, the requester holds it and its operands stable until ready. The arbiter never drops a request that is pending.
- Fairness: with both requesters valid continuously, grants strictly alternate.

## Timing
- Reset values:
  - state = IDLE
  - owner = 0
  - last_grant = 1, so requester 0 wins the first tie
  - result_reg = 0
  - all `*_valid_o` and `*_ready_o` = 0
  - `alu_*_o` = 0
- Latency: an accept in cycle T gives `rspN_valid_o` high in cycle T+1.
- Back-pressure: while `rsp<owner>_ready_i` is low in RESP:
  - result_reg, owner and `rsp*_o` hold stable;
  - both `reqN_ready_o` are 0.
- Reset in RESP: the held result is discarded and the next cycle shows the reset values. Pending requests re-arbitrate from last_grant=1.
- Reset asserted in the same cycle as an accept: reset wins and the accepted operation is lost. The requester observed ready=1, so the system-level reset must also reset the requesters.

## Structure
- Add to admo_defs.v:
  - state encodings `ARB_IDLE`/`ARB_RESP` (1 bit);
  - requester index width.
- Reuse the existing `` `ALU_* `` operator codes.
- The ALU stays outside the arbiter; `admo_alu` instances pair with the arbiter at the integration level.
- The testbench instantiates `admo_alu_arbiter` together with `admo_alu`.
- No sub-module needed; the round-robin pick is a small combinational function within the block.

## Test plan
- Single request: req0 ADD 5+3, rsp0_ready=1 → req0_ready high in the same cycle; next cycle rsp0_valid=1, result 8; then IDLE.
- Simultaneous first request after reset: req0 ADD 1+1, req1 XOR F0^0F → req0 granted first (result 2), req1 next cycle (result FF).
- Continuous load: both valid for 6 ops, rsp ready always high → grants alternate 0,1,0,1,0,1; one response per cycle.
- Back-pressure: req1 SUB 0−1, rsp1_ready low 3 cycles with req0 valid → rsp1_result holds 32'hFFFFFFFF; req0_ready=0 throughout; req0 accepted in the cycle rsp1_ready rises.
- Reset in RESP: rst_i pulsed while rsp0_valid=1 → next cycle all valids 0; a req1 pending alone is granted on the first cycle after reset.
- Operator coverage: AND, OR and an unknown operator 4'hF on A=32'h1234 → ALU outputs returned unchanged (unknown operator passes A=32'h1234).

Source files
------------

// File: rtl/admo_alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter and the ALU it fronts:
// operator codes, FSM state encoding and requester index type.
package admo_alu_arbiter_pkg;

  localparam int ARB_DATA_WIDTH = 32;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLL = 4'h5;
  localparam logic [3:0] ALU_SRL = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;

  localparam int REQ_IDX_W = 1;
  typedef logic [REQ_IDX_W-1:0] req_idx_t;
  localparam req_idx_t REQ0 = 1'b0;
  localparam req_idx_t REQ1 = 1'b1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/admo_alu.sv
// Combinational ALU shared behind admo_alu_arbiter. Unknown operator
// codes pass operand A through unchanged.
module admo_alu
  import admo_alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = ARB_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic [3:0]            operator_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic signed [DATA_WIDTH-1:0] a_s;
  logic signed [DATA_WIDTH-1:0] b_s;
  logic [SHW-1:0]               shamt;

  assign a_s   = operand_a_i;
  assign b_s   = operand_b_i;
  assign shamt = operand_b_i[SHW-1:0];

  always_comb begin
    result_o = operand_a_i;
    case (operator_i)
      ALU_ADD: result_o = operand_a_i + operand_b_i;
      ALU_SUB: result_o = operand_a_i - operand_b_i;
      ALU_AND: result_o = operand_a_i & operand_b_i;
      ALU_OR:  result_o = operand_a_i | operand_b_i;
      ALU_XOR: result_o = operand_a_i ^ operand_b_i;
      ALU_SLL: result_o = operand_a_i << shamt;
      ALU_SRL: result_o = operand_a_i >> shamt;
      ALU_SLT: result_o = {{(DATA_WIDTH-1){1'b0}}, (a_s < b_s)};
      default: result_o = operand_a_i;
    endcase
  end

endmodule

// File: rtl/admo_alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a single registered result returned on a per-requester handshake.
module admo_alu_arbiter
  import admo_alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = ARB_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [DATA_WIDTH-1:0] req0_operand_a_i,
  input  logic [DATA_WIDTH-1:0] req0_operand_b_i,
  input  logic [3:0]            req0_operator_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [DATA_WIDTH-1:0] req1_operand_a_i,
  input  logic [DATA_WIDTH-1:0] req1_operand_b_i,
  input  logic [3:0]            req1_operator_i,
  output logic                  rsp0_valid_o,
  input  logic                  rsp0_ready_i,
  output logic [DATA_WIDTH-1:0] rsp0_result_o,
  output logic                  rsp1_valid_o,
  input  logic                  rsp1_ready_i,
  output logic [DATA_WIDTH-1:0] rsp1_result_o,
  output logic [DATA_WIDTH-1:0] alu_operand_a_o,
  output logic [DATA_WIDTH-1:0] alu_operand_b_o,
  output logic [3:0]            alu_operator_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i
);

  arb_state_e            state_q, state_d;
  req_idx_t              owner_q, owner_d;
  req_idx_t              last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic     rsp_done;
  logic     slot_open;
  logic     gnt_vld;
  req_idx_t gnt;

  // On a tie the requester that did not win last time goes next.
  function automatic req_idx_t rr_pick(input logic v0, input logic v1,
                                       input req_idx_t last);
    if (v0 && v1) return (last == REQ0) ? REQ1 : REQ0;
    if (v0)       return REQ0;
    return REQ1;
  endfunction

  always_comb begin
    rsp_done  = (state_q == ARB_RESP) &&
                ((owner_q == REQ0) ? rsp0_ready_i : rsp1_ready_i);
    slot_open = (state_q == ARB_IDLE) || rsp_done;
    gnt       = rr_pick(req0_valid_i, req1_valid_i, last_grant_q);
    gnt_vld   = slot_open && (req0_valid_i || req1_valid_i);
  end

  assign req0_ready_o = gnt_vld && (gnt == REQ0);
  assign req1_ready_o = gnt_vld && (gnt == REQ1);

  always_comb begin
    alu_operand_a_o = '0;
    alu_operand_b_o = '0;
    alu_operator_o  = 4'h0;
    if (gnt_vld) begin
      if (gnt == REQ0) begin
        alu_operand_a_o = req0_operand_a_i;
        alu_operand_b_o = req0_operand_b_i;
        alu_operator_o  = req0_operator_i;
      end else begin
        alu_operand_a_o = req1_operand_a_i;
        alu_operand_b_o = req1_operand_b_i;
        alu_operator_o  = req1_operator_i;
      end
    end
  end

  // A completing response and a new accept may share a cycle; RESP is kept.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    if (gnt_vld) begin
      state_d      = ARB_RESP;
      owner_d      = gnt;
      last_grant_d = gnt;
      result_d     = alu_result_i;
    end else if (rsp_done) begin
      state_d = ARB_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ARB_IDLE;
      owner_q      <= REQ0;
      last_grant_q <= REQ1;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
    end
  end

  assign rsp0_valid_o  = (state_q == ARB_RESP) && (owner_q == REQ0);
  assign rsp1_valid_o  = (state_q == ARB_RESP) && (owner_q == REQ1);
  assign rsp0_result_o = result_q;
  assign rsp1_result_o = result_q;

endmodule

// File: tb/tb_admo_alu_arbiter.sv
// Directed bench for admo_alu_arbiter paired with admo_alu, with a
// per-requester scoreboard of expected results.
module tb_admo_alu_arbiter;
  import admo_alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  op0, op1;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [3:0]  alu_op;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  admo_alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
    .req0_operand_a_i(a0), .req0_operand_b_i(b0), .req0_operator_i(op0),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
    .req1_operand_a_i(a1), .req1_operand_b_i(b1), .req1_operator_i(op1),
    .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready), .rsp0_result_o(rsp0_result),
    .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready), .rsp1_result_o(rsp1_result),
    .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b), .alu_operator_o(alu_op),
    .alu_result_i(alu_r)
  );

  admo_alu #(.DATA_WIDTH(32)) alu (
    .operand_a_i(alu_a), .operand_b_i(alu_b), .operator_i(alu_op), .result_o(alu_r)
  );

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard: push on accept, pop and compare on response consumption.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) chk("sb_rsp0_unexpected", 32'd1, 32'd0);
        else chk("sb_rsp0", rsp0_result, q0.pop_front());
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) chk("sb_rsp1_unexpected", 32'd1, 32'd0);
        else chk("sb_rsp1", rsp1_result, q1.pop_front());
      end
      if (req0_valid && req0_ready) q0.push_back(model(a0, b0, op0));
      if (req1_valid && req1_ready) q1.push_back(model(a1, b1, op1));
    end
  end

  initial begin
    logic g;
    logic [31:0] exp_c [3];
    logic [3:0]  ops_c [3];
    logic [31:0] bs_c  [3];

    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    tick();
    mid();
    chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    chk("rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    chk("rst_result", rsp0_result, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
    tick();
    rst = 1'b0;

    // Single request
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; a0 = 32'd5; b0 = 32'd3; op0 = ALU_ADD;
    mid();
    chk("single_ready0", {31'b0, req0_ready}, 32'd1);
    chk("single_alu_a", alu_a, 32'd5);
    tick();
    req0_valid = 0;
    mid();
    chk("single_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("single_result", rsp0_result, 32'd8);
    tick();
    mid();
    chk("single_idle", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    tick();

    // Simultaneous first request after reset
    do_reset();
    req0_valid = 1; a0 = 32'd1; b0 = 32'd1; op0 = ALU_ADD;
    req1_valid = 1; a1 = 32'hF0; b1 = 32'h0F; op1 = ALU_XOR;
    mid();
    chk("tie_ready0", {30'b0, req1_ready, req0_ready}, 32'b01);
    tick();
    req0_valid = 0;
    mid();
    chk("tie_rsp0_result", rsp0_result, 32'd2);
    chk("tie_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("tie_ready1", {31'b0, req1_ready}, 32'd1);
    tick();
    req1_valid = 0;
    mid();
    chk("tie_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
    chk("tie_rsp1_result", rsp1_result, 32'hFF);
    tick();

    // Continuous load: grants alternate, one response per cycle
    a0 = 32'd100; b0 = 32'd1; op0 = ALU_ADD;
    a1 = 32'd50;  b1 = 32'd3; op1 = ALU_SUB;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      mid();
      chk("cont_onehot", {31'b0, req0_ready ^ req1_ready}, 32'd1);
      chk("cont_grant", {31'b0, req1_ready}, 32'(i % 2));
      if (i > 0) chk("cont_rsp", {31'b0, rsp0_valid | rsp1_valid}, 32'd1);
      g = req1_ready;
      tick();
      if (!g) begin a0 = a0 + 32'd17; b0 = b0 + 32'd2; end
      else    begin a1 = a1 + 32'd9; op1 = ALU_XOR; end
    end
    req0_valid = 0; req1_valid = 0;
    mid();
    chk("cont_last_rsp1", {31'b0, rsp1_valid}, 32'd1);
    tick();
    mid();
    chk("cont_drained", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    tick();

    // Back-pressure on requester 1
    rsp1_ready = 0;
    req1_valid = 1; a1 = 32'd0; b1 = 32'd1; op1 = ALU_SUB;
    mid();
    chk("bp_ready1", {31'b0, req1_ready}, 32'd1);
    tick();
    req1_valid = 0;
    req0_valid = 1; a0 = 32'd7; b0 = 32'd9; op0 = ALU_ADD;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("bp_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
      chk("bp_rsp1_hold", rsp1_result, 32'hFFFF_FFFF);
      chk("bp_no_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
      tick();
    end
    rsp1_ready = 1;
    mid();
    chk("bp_release_ready0", {31'b0, req0_ready}, 32'd1);
    tick();
    req0_valid = 0;
    mid();
    chk("bp_rsp0_result", rsp0_result, 32'd16);
    tick();

    // Reset while a result is held
    rsp0_ready = 0;
    req0_valid = 1; a0 = 32'd2; b0 = 32'd2; op0 = ALU_ADD;
    mid();
    chk("rr_accept0", {31'b0, req0_ready}, 32'd1);
    tick();
    req0_valid = 0;
    req1_valid = 1; a1 = 32'hA0; b1 = 32'h05; op1 = ALU_OR;
    rst = 1;
    mid();
    chk("rr_held", {31'b0, rsp0_valid}, 32'd1);
    chk("rr_blocked1", {31'b0, req1_ready}, 32'd0);
    tick();
    rst = 0;
    mid();
    chk("rr_valids_cleared", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rr_result_cleared", rsp0_result, 32'd0);
    chk("rr_ready1", {31'b0, req1_ready}, 32'd1);
    tick();
    req1_valid = 0;
    rsp0_ready = 1;
    mid();
    chk("rr_rsp1_result", rsp1_result, 32'hA5);
    tick();

    // Operator coverage, including an unknown code
    ops_c[0] = ALU_AND; bs_c[0] = 32'h00FF; exp_c[0] = 32'h0034;
    ops_c[1] = ALU_OR;  bs_c[1] = 32'h0F00; exp_c[1] = 32'h1F34;
    ops_c[2] = 4'hF;    bs_c[2] = 32'h5555; exp_c[2] = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; a0 = 32'h1234; b0 = bs_c[i]; op0 = ops_c[i];
      mid();
      chk("op_ready0", {31'b0, req0_ready}, 32'd1);
      tick();
      req0_valid = 0;
      mid();
      chk("op_result", rsp0_result, exp_c[i]);
      tick();
    end

    tick();
    mid();
    chk("sb_drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
